mem_port_arbiter: RTL and testbench

- Shares one unified, variable-latency memory port between the fetch stage (instruction reads) and the memory stage (loads/stores).
- Sequences each transaction through a request/ack handshake and returns read data to the winning requester.
- Generates stallF / stallM, which the hazard unit ORs into its pipeline stall.
- Data port has priority; a starvation counter guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and the data stage.
// Optional ack watchdog with sticky timeout_err is built when ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [3:0]    dm_mode,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_valid,
    output logic          mem_req,
    output logic          mem_we,
    output logic [3:0]    mem_mode,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
`ifdef ARB_TIMEOUT_EN
    output logic          timeout_err,
`endif
    output logic          stallF,
    output logic          stallM
);

    localparam int unsigned CW        = 4;
    localparam logic [3:0]  MODE_WORD = 4'b0010;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    state_t        state, state_next;
    logic [CW-1:0] starve_cnt;
    logic          fetch_forced;
    logic          grant_i, grant_d, done;
    logic          busy;
    logic          timed_out;
    logic [DW-1:0] resp_data;

    assign busy = (state == BUSY_I) || (state == BUSY_D);

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt;

    assign timed_out = busy && !mem_ack && (to_cnt == TW'(TIMEOUT - 1));

    // Watchdog counts BUSY cycles without ack; error flag is sticky until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (busy && !done) to_cnt <= to_cnt + TW'(1);
            else               to_cnt <= '0;
            if (timed_out) timeout_err <= 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    assign resp_data = timed_out ? DW'(32'hDEAD_BEEF) : mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Data wins in IDLE unless fetch has waited STARVE_LIMIT data grants
    always_comb begin
        state_next   = state;
        grant_i      = 1'b0;
        grant_d      = 1'b0;
        done         = 1'b0;
        fetch_forced = if_req && (starve_cnt == CW'(STARVE_LIMIT));
        case (state)
            IDLE: begin
                if (dm_req && !fetch_forced) begin
                    grant_d    = 1'b1;
                    state_next = BUSY_D;
                end else if (if_req) begin
                    grant_i    = 1'b1;
                    state_next = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack || timed_out) begin
                    done       = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory-side request registers, response capture and starvation tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_mode   <= 4'b0000;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_valid   <= 1'b0;
            dm_valid   <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            if (grant_d) begin
                mem_req   <= 1'b1;
                mem_we    <= dm_we;
                mem_mode  <= dm_mode;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
            end else if (grant_i) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_mode  <= MODE_WORD;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end
            if (done) begin
                mem_req <= 1'b0;
                if (state == BUSY_I) begin
                    if_rdata <= resp_data;
                    if_valid <= 1'b1;
                end else begin
                    dm_rdata <= resp_data;
                    dm_valid <= 1'b1;
                end
            end
            if (grant_i || (state == IDLE && !if_req))
                starve_cnt <= '0;
            else if (grant_d && if_req && (starve_cnt != '1))
                starve_cnt <= starve_cnt + CW'(1);
        end
    end

    assign stallF = if_req & ~if_valid;
    assign stallM = dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; define ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          dm_req;
    logic          dm_we;
    logic [3:0]    dm_mode;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_valid;
    logic          mem_req;
    logic          mem_we;
    logic [3:0]    mem_mode;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
`ifdef ARB_TIMEOUT_EN
    logic          timeout_err;
`endif
    logic          stallF;
    logic          stallM;

    int vectors = 0;
    int errors  = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(3), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_mode(dm_mode), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_mode(mem_mode), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
`ifdef ARB_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .stallF(stallF), .stallM(stallM)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_mode = 4'b0; dm_addr = '0; dm_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        tick(); tick();
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_mode", 64'(mem_mode), 64'd0);
        check("rst_valids", 64'({if_valid, dm_valid}), 64'd0);
        check("rst_rdata", 64'({if_rdata, dm_rdata}), 64'd0);
`ifdef ARB_TIMEOUT_EN
        check("rst_timeout_err", 64'(timeout_err), 64'd0);
`endif
        rst = 1'b0;
        tick();

        // Fetch only, ack in first mem_req cycle
        if_req = 1'b1; if_addr = 32'h100;
        #1 check("f_stall_c0", 64'(stallF), 64'd1);
        check("f_memreq_c0", 64'(mem_req), 64'd0);
        tick();
        check("f_memreq_c1", 64'(mem_req), 64'd1);
        check("f_addr_c1", 64'(mem_addr), 64'h100);
        check("f_we_mode_c1", 64'({mem_we, mem_mode}), 64'h02);
        check("f_stall_c1", 64'(stallF), 64'd1);
        mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
        tick();
        mem_ack = 1'b0;
        check("f_valid_c2", 64'(if_valid), 64'd1);
        check("f_rdata_c2", 64'(if_rdata), 64'h0050_0093);
        check("f_memreq_c2", 64'(mem_req), 64'd0);
        check("f_stall_c2", 64'(stallF), 64'd0);
        tick();
        if_req = 1'b0;
        check("f_valid_c3", 64'(if_valid), 64'd0);
        check("f_rdata_hold", 64'(if_rdata), 64'h0050_0093);
        tick();

        // Simultaneous fetch and load, ack latency 2: data first
        if_req = 1'b1; if_addr = 32'h104;
        dm_req = 1'b1; dm_we = 1'b0; dm_mode = 4'b0010; dm_addr = 32'h2000;
        tick();
        check("b_addr_c1", 64'(mem_addr), 64'h2000);
        check("b_memreq_c1", 64'(mem_req), 64'd1);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        mem_ack = 1'b0;
        check("b_dvalid_c3", 64'({dm_valid, if_valid}), 64'b10);
        check("b_drdata_c3", 64'(dm_rdata), 64'h1111_2222);
        check("b_stallF_c3", 64'(stallF), 64'd1);
        tick();
        dm_req = 1'b0;
        check("b_stallM_c4", 64'(stallM), 64'd0);
        check("b_stallF_c4", 64'(stallF), 64'd1);
        tick();
        check("b_iaddr_c5", 64'(mem_addr), 64'h104);
        tick();
        check("b_stallF_c6", 64'(stallF), 64'd1);
        mem_ack = 1'b1; mem_rdata = 32'h3333_4444;
        tick();
        mem_ack = 1'b0;
        check("b_ivalid_c7", 64'({if_valid, dm_valid}), 64'b10);
        check("b_irdata_c7", 64'(if_rdata), 64'h3333_4444);
        tick();
        if_req = 1'b0;
        tick();

        // Starvation: three data grants then a forced fetch grant
        if_req = 1'b1; if_addr = 32'h200; dm_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dm_addr = 32'h4000 + 32'(4 * k);
            tick();
            check($sformatf("s_addr_%0d", k), 64'(mem_addr),
                  (k == 3) ? 64'h200 : 64'(32'h4000 + 32'(4 * k)));
            mem_ack = 1'b1; mem_rdata = 32'(k);
            tick();
            mem_ack = 1'b0;
            check($sformatf("s_valid_%0d", k), 64'({if_valid, dm_valid}),
                  (k == 3) ? 64'b10 : 64'b01);
            tick();
        end
        if_req = 1'b0; dm_req = 1'b0;
        check("s_cnt_after", 64'(dut.starve_cnt), 64'd0);
        tick();

        // Store with byte mode, slow ack
        dm_req = 1'b1; dm_we = 1'b1; dm_mode = 4'b0000; dm_addr = 32'h3; dm_wdata = 32'hAB;
        tick();
        check("st_fields_c1", 64'({mem_req, mem_we, mem_mode}), 64'b1_1_0000);
        check("st_addr_c1", 64'(mem_addr), 64'h3);
        check("st_wdata_c1", 64'(mem_wdata), 64'hAB);
        tick();
        check("st_hold_c2", 64'({mem_req, mem_we, mem_mode}), 64'b1_1_0000);
        check("st_addr_c2", 64'(mem_addr), 64'h3);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("st_valid_c3", 64'(dm_valid), 64'd1);
        tick();
        dm_req = 1'b0; dm_we = 1'b0;
        check("st_valid_c4", 64'(dm_valid), 64'd0);
        check("st_memreq_c4", 64'(mem_req), 64'd0);
        tick();

        // Async reset during BUSY_D, then a stale ack after release
        dm_req = 1'b1; dm_addr = 32'h5000;
        tick();
        check("r_memreq_c1", 64'(mem_req), 64'd1);
        #2 rst = 1'b1;
        #1 check("r_memreq_async", 64'(mem_req), 64'd0);
        check("r_drdata_async", 64'(dm_rdata), 64'd0);
        dm_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        tick();
        mem_ack = 1'b0;
        check("r_no_valid", 64'({if_valid, dm_valid}), 64'd0);
        check("r_memreq_idle", 64'(mem_req), 64'd0);
        tick();
        check("r_no_valid2", 64'({if_valid, dm_valid}), 64'd0);
        check("r_drdata_kept", 64'(dm_rdata), 64'd0);

`ifdef ARB_TIMEOUT_EN
        // No ack at all: watchdog ends the transaction after 64 BUSY cycles
        begin
            int n;
            n = 0;
            dm_req = 1'b1; dm_addr = 32'h6000;
            for (int i = 0; i < 200; i++) begin
                tick();
                if (mem_req) n++;
                else break;
            end
            check("t_busy_cycles", 64'(n), 64'd64);
            check("t_valid", 64'(dm_valid), 64'd1);
            check("t_rdata", 64'(dm_rdata), 64'hDEAD_BEEF);
            check("t_err_set", 64'(timeout_err), 64'd1);
            tick();
            dm_req = 1'b0;
            tick();
            check("t_err_sticky", 64'(timeout_err), 64'd1);
            rst = 1'b1;
            tick();
            check("t_err_clr", 64'(timeout_err), 64'd0);
            rst = 1'b0;
            tick();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
